sw_port_tx: RTL and testbench
=============================

SW_PORT_TX -- requirements
Module: sw_port_tx

Interface
REQ-001: Parameter DEPTH, default 64, sets the byte-buffer depth in entries (power of two, 16..256).
REQ-002: Parameter DW, default 8, sets the data byte width.
REQ-003: clk  input  1  single clock; all logic on posedge clk.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: in_valid  input  1  switch core presents a byte.
REQ-006: in_data  input  DW  byte from switch core.
REQ-007: in_last  input  1  marks the final byte of a packet.
REQ-008: in_ready  output  1  buffer can accept a byte this cycle.
REQ-009: port_ready  output  1  at least one complete packet is buffered, or a packet is being sent.
REQ-010: port_read  input  1  downstream requests one byte per cycle.
REQ-011: port_data  output  DW  byte delivered to downstream.
REQ-012: port_valid  output  1  port_data is valid this cycle.
REQ-013: port_busy  output  1  a packet transfer is in progress.

Function
REQ-014: A byte is accepted on a cycle with in_valid=1 and in_ready=1; it is stored as {in_last, in_data}.
REQ-015: in_ready = 1 when the buffer holds fewer than DEPTH entries; in_valid while in_ready=0 is ignored, with no write and no state change.
REQ-016: pkt_cnt (width clog2(DEPTH)+1) increments on an accepted byte with in_last=1 and decrements when the last byte of a packet is popped; a simultaneous increment and decrement leaves it unchanged.
REQ-017: FSM states: IDLE, SEND.
REQ-018: IDLE -> SEND occurs when pkt_cnt>0 and port_read=1; that cycle pops the first byte.
REQ-019: In SEND, each cycle with port_read=1 pops one byte; port_read=0 pauses the transfer with no pop, and port_valid is 0 on the next cycle.
REQ-020: Latency: a byte popped in cycle N appears on port_data with port_valid=1 in cycle N+1 (registered output).
REQ-021: Popping a byte whose stored last flag is 1 returns the FSM to IDLE on the next cycle; back-to-back packets require at least one IDLE cycle.
REQ-022: port_busy = 1 in SEND, and also during the cycle that delivers the last byte.
REQ-023: port_ready = (pkt_cnt>0) or (state==SEND).
REQ-024: port_read in IDLE with pkt_cnt=0 is ignored, and port_valid stays 0.
REQ-025: Read and write pointers wrap modulo DEPTH; a simultaneous push and pop when full is allowed only if in_ready was 1 (no push-through when full).
REQ-026: The switch core never sends a packet longer than DEPTH bytes; if the buffer is full and pkt_cnt=0, in_ready stays 0 (no deadlock recovery is required).
REQ-027: port_data holds its last value when port_valid=0.

Reset
REQ-028: When rst_n=0: state=IDLE, pointers=0, pkt_cnt=0, in_ready=0 while reset is asserted, port_valid=0, port_busy=0, port_ready=0, port_data=0.
REQ-029: A reset asserted mid-packet discards all buffered data, including partial packets; after release, in_ready=1 on the first clock edge.
REQ-030: rst_n assertion takes effect asynchronously, and its deassertion is synchronized by the surrounding system.

Structure
REQ-031: Shared package sw_pkg holds DW default, DEPTH default, and the state enum tx_state_t {IDLE, SEND}.
REQ-032: Storage is one sub-module, sw_byte_fifo (DW+1 wide, DEPTH deep, synchronous, full/empty/count outputs); the FSM, pkt_cnt and output register live in sw_port_tx.

Verification
REQ-033: Write packet 0x05,0x01,0x02,0xAA (last) with port_read held high -> port_ready rises the cycle after last is accepted; port_data shows 05,01,02,AA on 4 consecutive cycles; port_busy falls after AA.
REQ-034: Two 3-byte packets buffered, port_read constant 1 -> pkt_cnt goes 2->1->0; exactly one port_valid=0 gap between the packets.
REQ-035: During SEND of a 6-byte packet, toggle port_read 1,0,0,1... -> no byte lost or duplicated; port_valid=0 during the pauses; order preserved.
REQ-036: Fill 64 bytes without reading -> in_ready=0 at count 64; a 65th in_valid is ignored; reading one byte re-asserts in_ready the next cycle.
REQ-037: Assert rst_n=0 after 2 of 5 bytes are sent -> all outputs return to reset values; a new packet after release is transmitted intact.
REQ-038: Accept a last byte in the same cycle the final byte of another packet is popped -> pkt_cnt unchanged and port_ready stays 1.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the switch transmit port: default widths and FSM state type.
package sw_pkg;

  localparam int SW_DW    = 8;
  localparam int SW_DEPTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sw_byte_fifo.sv
// Synchronous byte FIFO holding {last, data} entries; read data is the current head.
module sw_byte_fifo
  import sw_pkg::*;
#(
  parameter int DEPTH = SW_DEPTH,
  parameter int WIDTH = SW_DW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sw_port_tx.sv
// Transmit port: buffers bytes from the switch core and releases only whole packets downstream.
module sw_port_tx
  import sw_pkg::*;
#(
  parameter int DEPTH = SW_DEPTH,
  parameter int DW    = SW_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          port_ready,
  input  logic          port_read,
  output logic [DW-1:0] port_data,
  output logic          port_valid,
  output logic          port_busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_t      state;
  logic [CW-1:0]  pkt_cnt;
  logic [DW:0]    head;
  logic           head_last;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           push;
  logic           pop;
  logic           pkt_in;
  logic           pkt_out;

  sw_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({in_last, in_data}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head_last  = head[DW];
  assign in_ready   = rst_n && (fifo_count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign port_ready = (pkt_cnt != '0) || (state == SEND);

  // In IDLE, port_busy is only high while the previous packet's last byte is on the
  // output; holding off the next start then gives the mandatory gap between packets.
  always_comb begin
    pop = 1'b0;
    if (port_read && !fifo_empty) begin
      if (state == SEND) pop = 1'b1;
      else               pop = (pkt_cnt != '0) && !port_busy;
    end
  end

  assign pkt_in  = push && in_last;
  assign pkt_out = pop && head_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pkt_cnt    <= '0;
      port_valid <= 1'b0;
      port_data  <= '0;
      port_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (pop && !head_last) state <= SEND;
        SEND:    if (pkt_out)           state <= IDLE;
        default:                        state <= IDLE;
      endcase
      case ({pkt_in, pkt_out})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
      port_valid <= pop;
      if (pop) port_data <= head[DW-1:0];
      port_busy  <= (state == SEND) || pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && fifo_full));
  end

endmodule

// File: tb/tb_sw_port_tx.sv
// Self-checking bench for sw_port_tx against a queue-based packet model.
module tb_sw_port_tx;

  localparam int DEPTH = 64;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          port_read = 1'b0;
  logic          in_ready;
  logic          port_ready;
  logic [DW-1:0] port_data;
  logic          port_valid;
  logic          port_busy;

  sw_port_tx #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .port_ready (port_ready),
    .port_read  (port_read),
    .port_data  (port_data),
    .port_valid (port_valid),
    .port_busy  (port_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bytes waiting in the buffer, complete packets waiting, and transfer progress.
  logic [8:0] mdl_buf [$];
  int         mdl_pkts;
  bit         mdl_sending;
  bit         mdl_tail;
  bit         exp_valid;
  bit         exp_busy;
  logic [7:0] exp_data;

  wire [11:0] observed = {port_valid, port_busy, port_ready, in_ready, port_data};

  function automatic logic [11:0] expected_outputs();
    logic r, ir;
    r  = (mdl_pkts > 0) || mdl_sending;
    ir = (mdl_buf.size() < DEPTH);
    return {exp_valid, exp_busy, r, ir, exp_data};
  endfunction

  task automatic model_reset();
    mdl_buf.delete();
    mdl_pkts    = 0;
    mdl_sending = 1'b0;
    mdl_tail    = 1'b0;
    exp_valid   = 1'b0;
    exp_busy    = 1'b0;
    exp_data    = '0;
  endtask

  // Drives one cycle of stimulus and advances the model past the clock edge.
  task automatic run_cycle(input bit iv, input logic [7:0] id, input bit il, input bit pr);
    bit         push, pop;
    logic [8:0] e;
    in_valid  = iv;
    in_data   = id;
    in_last   = il;
    port_read = pr;
    push = iv && (mdl_buf.size() < DEPTH);
    pop  = pr && (mdl_buf.size() > 0) && (mdl_sending || (mdl_pkts > 0 && !mdl_tail));
    @(posedge clk);
    #1;
    mdl_tail  = 1'b0;
    exp_valid = pop;
    if (pop) begin
      e = mdl_buf.pop_front();
      exp_data = e[7:0];
      if (e[8]) begin
        mdl_pkts--;
        mdl_sending = 1'b0;
        mdl_tail    = 1'b1;
      end else begin
        mdl_sending = 1'b1;
      end
    end
    exp_busy = mdl_sending || mdl_tail;
    if (push) begin
      mdl_buf.push_back({il, id});
      if (il) mdl_pkts++;
    end
    in_valid  = 1'b0;
    port_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observed !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_values got %h want %h", observed, 12'h000);
    end
    rst_n = 1'b1;
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || observed !== expected_outputs()) begin
      errors++;
      $display("[TB] FAIL reset_release got %h want %h", observed, expected_outputs());
    end
  endtask

  task automatic test_basic();
    logic [7:0] pkt [4] = '{8'h05, 8'h01, 8'h02, 8'hAA};
    logic [7:0] got [$];
    int first = -1, last = -1;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) run_cycle(1'b1, pkt[i], i == 3, 1'b1);
      else       run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (observed !== expected_outputs()) begin
        errors++;
        $display("[TB] FAIL basic cyc %0d got %h want %h", i, observed, expected_outputs());
      end
      if (port_valid === 1'b1) begin
        got.push_back(port_data);
        if (first < 0) first = i;
        last = i;
      end
    end
    checks++;
    if (got.size() != 4 || last - first != 3) begin
      errors++;
      $display("[TB] FAIL basic_stream got %0d bytes over %0d cycles want 4 over 4", got.size(), last - first + 1);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== pkt[i]) begin
          errors++;
          $display("[TB] FAIL basic_byte%0d got %h want %h", i, got[i], pkt[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int gaps = 0, first = -1, last = -1;
    bit vpat [16];
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, 8'($urandom), (i == 2) || (i == 5), 1'b0);
      checks++;
      if (observed !== expected_outputs()) begin
        errors++;
        $display("[TB] FAIL b2b_fill cyc %0d got %h want %h", i, observed, expected_outputs());
      end
    end
    for (int i = 0; i < 16; i++) begin
      run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (observed !== expected_outputs()) begin
        errors++;
        $display("[TB] FAIL b2b cyc %0d got %h want %h", i, observed, expected_outputs());
      end
      vpat[i] = (port_valid === 1'b1);
      if (vpat[i]) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    for (int i = 0; i < 16; i++) if (first >= 0 && i > first && i < last && !vpat[i]) gaps++;
    checks++;
    if (gaps != 1 || last - first != 6) begin
      errors++;
      $display("[TB] FAIL b2b_gap got gaps=%0d span=%0d want gaps=1 span=6", gaps, last - first);
    end
  endtask

  task automatic test_pause();
    logic [7:0] sent [$];
    logic [7:0] got [$];
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      run_cycle(1'b1, b, i == 5, 1'b0);
    end
    for (int k = 0; k < 24; k++) begin
      run_cycle(1'b0, 8'h00, 1'b0, (k % 3) == 0);
      checks++;
      if (observed !== expected_outputs()) begin
        errors++;
        $display("[TB] FAIL pause cyc %0d got %h want %h", k, observed, expected_outputs());
      end
      if (port_valid === 1'b1) got.push_back(port_data);
    end
    checks++;
    if (got != sent) begin
      errors++;
      $display("[TB] FAIL pause_stream got %0d bytes want %0d in order", got.size(), sent.size());
    end
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 8'(8'h30 + i), i == 2, 1'b0);
    run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    run_cycle(1'b1, 8'h35, 1'b1, 1'b1);
    checks++;
    if (port_ready !== 1'b1 || observed !== expected_outputs()) begin
      errors++;
      $display("[TB] FAIL overlap got %h want %h", observed, expected_outputs());
    end
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (observed !== expected_outputs()) begin
        errors++;
        $display("[TB] FAIL overlap_drain cyc %0d got %h want %h", i, observed, expected_outputs());
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] got [$];
    for (int i = 0; i < DEPTH; i++) run_cycle(1'b1, 8'(i), i == DEPTH - 1, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || observed !== expected_outputs()) begin
      errors++;
      $display("[TB] FAIL full_ready got %h want %h", observed, expected_outputs());
    end
    run_cycle(1'b1, 8'h77, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || observed !== expected_outputs()) begin
      errors++;
      $display("[TB] FAIL full_extra got %h want %h", observed, expected_outputs());
    end
    run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1 || observed !== expected_outputs()) begin
      errors++;
      $display("[TB] FAIL full_reopen got %h want %h", observed, expected_outputs());
    end
    if (port_valid === 1'b1) got.push_back(port_data);
    for (int i = 0; i < 75; i++) begin
      run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (observed !== expected_outputs()) begin
        errors++;
        $display("[TB] FAIL full_drain cyc %0d got %h want %h", i, observed, expected_outputs());
      end
      if (port_valid === 1'b1) got.push_back(port_data);
    end
    checks++;
    if (got.size() != DEPTH) begin
      errors++;
      $display("[TB] FAIL full_count got %0d bytes want %0d", got.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (got[i] !== 8'(i)) begin
          checks++;
          errors++;
          $display("[TB] FAIL full_byte%0d got %h want %h", i, got[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] sent [$];
    logic [7:0] got [$];
    logic [7:0] b;
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 8'(8'hC0 + i), i == 4, 1'b0);
    run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observed !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_mid got %h want %h", observed, 12'h000);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        b = 8'($urandom);
        sent.push_back(b);
        run_cycle(1'b1, b, i == 3, 1'b1);
      end else begin
        run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      end
      checks++;
      if (observed !== expected_outputs()) begin
        errors++;
        $display("[TB] FAIL reset_mid_pkt cyc %0d got %h want %h", i, observed, expected_outputs());
      end
      if (port_valid === 1'b1) got.push_back(port_data);
    end
    checks++;
    if (got != sent) begin
      errors++;
      $display("[TB] FAIL reset_mid_stream got %0d bytes want %0d in order", got.size(), sent.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run_cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) < 7);
      checks++;
      if (observed !== expected_outputs()) begin
        errors++;
        $display("[TB] FAIL random cyc %0d got %h want %h", i, observed, expected_outputs());
      end
    end
    run_cycle(1'b1, 8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 150; i++) begin
      run_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (observed !== expected_outputs()) begin
        errors++;
        $display("[TB] FAIL random_drain cyc %0d got %h want %h", i, observed, expected_outputs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_pause();
    test_overlap();
    test_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
